// File: rtl/correlator_sequencer_pkg.sv
// Shared defaults and types for the correlator sequencer and the correlator blocks it drives.
package correlator_sequencer_pkg;

  localparam int unsigned TRATE_DEF   = 12;
  localparam int unsigned TBITS_DEF   = 4;
  localparam int unsigned LATENCY_DEF = 3;
  localparam int unsigned CBITS_DEF   = 24;
  localparam int unsigned BSBITS      = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/correlator_sequencer_shift_delay.sv
// Registered delay line of DEPTH stages, WIDTH bits wide, asynchronously cleared.
module shift_delay #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk_x,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk_x or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/correlator_sequencer.sv
// Slot sequencer for the time-multiplexed correlators: walks rd through all slots per sample,
// tracks accumulation blocks and flips the output bank once the last writes have drained.
module correlator_sequencer
  import correlator_sequencer_pkg::*;
#(
  parameter int unsigned TRATE   = TRATE_DEF,
  parameter int unsigned TBITS   = TBITS_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned CBITS   = CBITS_DEF
) (
  input  logic              clk_x,
  input  logic              rst,
  input  logic              enable,
  input  logic [BSBITS-1:0] blocksize,
  input  logic              strobe,
  output logic              ready,
  output logic              en,
  output logic              sw,
  output logic [TBITS-1:0]  rd,
  output logic [TBITS-1:0]  wr,
  output logic              bank,
  output logic              switched,
  output logic              overrun
);

  localparam int unsigned DBITS = $clog2(LATENCY + 1);
  localparam logic [TBITS-1:0] LAST_SLOT = TBITS'(TRATE - 1);

  seq_state_t        state;
  logic [CBITS-1:0]  count;
  logic [CBITS-1:0]  mask;
  logic [CBITS:0]    span;
  logic [BSBITS-1:0] bs_q;
  logic [DBITS-1:0]  drain;
  logic              clear_pending;
  logic              cp_nxt;
  logic              en_nxt;
  logic              last_slot;
  logic              block_end;
  logic              block_start;
  logic              accept;

  // A block starts either right after one ends or from an idle, zero count.
  always_comb begin
    last_slot   = (state == RUN) && (rd == LAST_SLOT);
    ready       = enable && ((state == IDLE) || (rd == LAST_SLOT));
    accept      = strobe && ready;
    span        = (CBITS+1)'(1) << bs_q;
    mask        = CBITS'(span - (CBITS+1)'(1));
    block_end   = last_slot && (count == mask);
    block_start = block_end || (!last_slot && (count == '0));
    en_nxt      = accept || ((state == RUN) && !last_slot);
    cp_nxt      = block_end ? 1'b1 : (last_slot ? 1'b0 : clear_pending);
  end

  always_ff @(posedge clk_x or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd            <= '0;
      en            <= 1'b0;
      sw            <= 1'b0;
      clear_pending <= 1'b1;
      count         <= '0;
      bs_q          <= '0;
    end else begin
      en            <= en_nxt;
      sw            <= en_nxt && cp_nxt;
      clear_pending <= cp_nxt;
      if (accept) begin
        state <= RUN;
        rd    <= '0;
        if (block_start) bs_q <= blocksize;
      end else if (last_slot) begin
        state <= IDLE;
        rd    <= '0;
      end else if (state == RUN) begin
        rd <= rd + TBITS'(1);
      end
      if (block_end)      count <= '0;
      else if (last_slot) count <= count + CBITS'(1);
    end
  end

  // Bank flips only after the final writes of a block have left the correlator pipeline.
  always_ff @(posedge clk_x or posedge rst) begin
    if (rst) begin
      drain    <= '0;
      bank     <= 1'b0;
      switched <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      switched <= 1'b0;
      if (block_end) begin
        drain <= DBITS'(LATENCY);
      end else if (drain != '0) begin
        drain <= drain - DBITS'(1);
        if (drain == DBITS'(1)) begin
          bank     <= ~bank;
          switched <= 1'b1;
        end
      end
      if (!enable)                overrun <= 1'b0;
      else if (strobe && !ready)  overrun <= 1'b1;
    end
  end

  shift_delay #(
    .WIDTH(TBITS),
    .DEPTH(LATENCY)
  ) u_wr_delay (
    .clk_x(clk_x),
    .rst  (rst),
    .din  (rd),
    .dout (wr)
  );

endmodule

// File: tb/tb_correlator_sequencer.sv
// Bench for correlator_sequencer: a per-cycle expectation schedule built from accepted samples.
module tb_correlator_sequencer;

  localparam int TR  = 12;
  localparam int LAT = 3;
  localparam int N   = 1024;

  logic       clk_x = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       strobe = 1'b0;
  logic [4:0] blocksize = '0;
  logic       ready, en, sw, bank, switched, overrun;
  logic [3:0] rd, wr;

  correlator_sequencer dut (
    .clk_x    (clk_x),
    .rst      (rst),
    .enable   (enable),
    .blocksize(blocksize),
    .strobe   (strobe),
    .ready    (ready),
    .en       (en),
    .sw       (sw),
    .rd       (rd),
    .wr       (wr),
    .bank     (bank),
    .switched (switched),
    .overrun  (overrun)
  );

  always #5 clk_x = ~clk_x;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int blk_cnt, blk_len;
  bit cp_m;

  // Expected outputs per cycle, filled in as samples are accepted.
  bit       m_en  [N];
  bit       m_sw  [N];
  bit       m_swp [N];
  bit       m_bank[N];
  bit       m_ov  [N];
  logic [3:0] m_rd[N];
  logic [3:0] m_wr[N];

  task automatic clear_model();
    for (int c = 0; c < N; c++) begin
      m_en[c] = 0; m_sw[c] = 0; m_swp[c] = 0; m_bank[c] = 0; m_ov[c] = 0;
      m_rd[c] = '0; m_wr[c] = '0;
    end
    cyc = 0; blk_cnt = 0; blk_len = 1; cp_m = 1'b1;
  endtask

  function automatic logic m_ready();
    return enable && (!m_en[cyc] || (m_rd[cyc] == 4'(TR - 1)));
  endfunction

  function automatic logic [13:0] obs();
    return {en, sw, rd, wr, bank, switched, overrun, ready};
  endfunction

  function automatic logic [13:0] expv(input logic r);
    return {m_en[cyc], m_sw[cyc], m_rd[cyc], m_wr[cyc], m_bank[cyc], m_swp[cyc], m_ov[cyc], r};
  endfunction

  // A sample accepted now occupies TR cycles starting at s; block accounting happens here.
  task automatic start_sample(input int s);
    if (blk_cnt == 0) blk_len = 1 << blocksize;
    for (int k = 0; k < TR; k++) begin
      m_en[s+k] = 1'b1;
      m_rd[s+k] = 4'(k);
      m_sw[s+k] = cp_m;
      m_wr[s+k+LAT] = 4'(k);
    end
    blk_cnt++;
    if (blk_cnt == blk_len) begin
      blk_cnt = 0;
      cp_m = 1'b1;
      m_swp[s+TR+LAT] = 1'b1;
      for (int c = s + TR + LAT; c < N; c++) m_bank[c] = !m_bank[c];
    end else begin
      cp_m = 1'b0;
    end
  endtask

  task automatic advance(input logic stb, input logic r);
    if (stb && r) start_sample(cyc + 1);
    m_ov[cyc+1] = !enable ? 1'b0 : ((stb && !r) ? 1'b1 : m_ov[cyc]);
    @(negedge clk_x);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; strobe = 1'b0; enable = 1'b0; blocksize = '0;
    @(negedge clk_x);
    @(negedge clk_x);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    logic [13:0] v;
    rst = 1'b1; enable = 1'b1; strobe = 1'b0;
    @(negedge clk_x); #1;
    v = obs();
    n_checks++;
    if (v[13:1] !== 13'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", v[13:1]);
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=1", ready);
    end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_single_sample();
    logic r; int en_cnt = 0; int sw_cnt = 0;
    do_reset();
    blocksize = 5'd1;
    for (int i = 0; i < 24; i++) begin
      enable = 1'b1; strobe = (i == 0);
      #1; r = m_ready();
      if (en === 1'b1) en_cnt++;
      if (sw === 1'b1) sw_cnt++;
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL single_sample cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      advance(strobe, r);
    end
    n_checks++;
    if (en_cnt != TR || sw_cnt != TR) begin
      n_fail++; $display("FAIL single_sample_len en=%0d sw=%0d exp=%0d", en_cnt, sw_cnt, TR);
    end
  endtask

  task automatic test_back_to_back();
    logic r; int left = 9; int pulses = 0;
    do_reset();
    blocksize = 5'd2;
    for (int i = 0; i < 9 * TR + 10; i++) begin
      enable = 1'b1;
      strobe = (left > 0) && m_ready();
      if (strobe) left--;
      #1; r = m_ready();
      if (switched === 1'b1) pulses++;
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      advance(strobe, r);
    end
    n_checks++;
    if (pulses != 2 || bank !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back_blocks pulses=%0d bank=%b exp 2/0", pulses, bank);
    end
  endtask

  task automatic test_overrun();
    logic r; int en_cnt = 0;
    do_reset();
    blocksize = 5'd1;
    for (int i = 0; i < 26; i++) begin
      enable = !(i == 20);
      strobe = (i == 0) || (i == 6);
      #1; r = m_ready();
      if (en === 1'b1) en_cnt++;
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL overrun cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      advance(strobe, r);
    end
    n_checks++;
    if (en_cnt != TR || overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_drop en=%0d ovr=%b exp %0d/0", en_cnt, overrun, TR);
    end
  endtask

  task automatic test_enable_drop();
    logic r; int pulses = 0; int pulse_at = -1;
    do_reset();
    blocksize = 5'd2;
    for (int i = 0; i < 64; i++) begin
      enable = !(i >= 16 && i < 31);
      strobe = (i == 0) || (i == 12) || (i == 32) || (i == 44);
      #1; r = m_ready();
      if (switched === 1'b1) begin pulses++; pulse_at = cyc; end
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL enable_drop cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      advance(strobe, r);
    end
    n_checks++;
    if (pulses != 1 || pulse_at != 60) begin
      n_fail++; $display("FAIL enable_drop_block pulses=%0d at=%0d exp 1 at 60", pulses, pulse_at);
    end
  endtask

  task automatic test_reset_midrun();
    logic r; logic [13:0] v; int sw_cnt = 0;
    do_reset();
    blocksize = 5'd0;
    for (int i = 0; i < 15; i++) begin
      enable = 1'b1; strobe = (i == 0) || (i == 12);
      #1; r = m_ready();
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL reset_midrun cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      if (i < 14) advance(strobe, r);
    end
    rst = 1'b1; strobe = 1'b0;
    #1; v = obs();
    n_checks++;
    if (v[13:1] !== 13'd0) begin
      n_fail++; $display("FAIL reset_async got=%h exp=0", v[13:1]);
    end
    @(negedge clk_x);
    @(negedge clk_x);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 24; i++) begin
      enable = 1'b1; strobe = (i == 6);
      #1; r = m_ready();
      if (sw === 1'b1) sw_cnt++;
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      advance(strobe, r);
    end
    n_checks++;
    if (sw_cnt != TR) begin
      n_fail++; $display("FAIL after_reset_sw got=%0d exp=%0d", sw_cnt, TR);
    end
  endtask

  task automatic test_every_sample_block();
    logic r; int pulses = 0; int sw_cnt = 0;
    do_reset();
    blocksize = 5'd0;
    for (int i = 0; i < 4 * TR + 10; i++) begin
      enable = 1'b1; strobe = (i % TR == 0) && (i < 4 * TR);
      #1; r = m_ready();
      if (switched === 1'b1) pulses++;
      if (sw === 1'b1) sw_cnt++;
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL bs0 cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      advance(strobe, r);
    end
    n_checks++;
    if (pulses != 4 || sw_cnt != 4 * TR || bank !== 1'b0) begin
      n_fail++; $display("FAIL bs0_totals pulses=%0d sw=%0d bank=%b exp 4/%0d/0", pulses, sw_cnt, bank, 4 * TR);
    end
  endtask

  task automatic test_random();
    logic r; logic ena = 1'b1;
    do_reset();
    blocksize = 5'($urandom_range(0, 2));
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) ena = !ena;
      if ($urandom_range(0, 49) == 0) blocksize = 5'($urandom_range(0, 2));
      enable = ena;
      strobe = ($urandom_range(0, 3) == 0);
      #1; r = m_ready();
      n_checks++;
      if (obs() !== expv(r)) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), expv(r));
      end
      advance(strobe, r);
    end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_back_to_back();
    test_overrun();
    test_enable_drop();
    test_reset_midrun();
    test_every_sample_block();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
